// File: rtl/mat_mul_seq.sv
// mat_mul_seq: sequential NxN unsigned matrix multiplier, S = A x B.
// One multiply-accumulate unit is time-multiplexed over all N^3 products.
// The operand pair is captured on acceptance. Each result element is written to
// s_mat as soon as its dot product completes. out_valid marks the point where
// the whole matrix is final.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   operand pair (a_mat, b_mat, sat_en) is valid
//   in_ready   block is idle and can accept an operand pair
//   a_mat      matrix A, element (i,j) at [(i*N+j)*W +: W]
//   b_mat      matrix B, same packing
//   sat_en     1: clamp each element to 2^W-1; 0: keep the low W bits
//   out_valid  s_mat holds a complete result
//   out_ready  consumer takes the result
//   s_mat      result matrix S, same packing
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an operand pair (in_ready=1)
// COMPUTE | one product per cycle, k fastest, then j, then i (N^3 cycles)
// DONE    | result held on s_mat until out_ready (out_valid=1)

module mat_mul_seq #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_mat,
  input  logic [N*N*W-1:0] b_mat,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] s_mat
);

  localparam int CW = $clog2(N);
  // A sum of N products of two W-bit values needs at most 2W+clog2(N) bits.
  localparam int AW = 2*W + CW;
  localparam logic [CW-1:0] LAST    = CW'(N-1);
  localparam logic [AW-1:0] SAT_MAX = AW'((1 << W) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]    a_arr [N][N];
  logic [W-1:0]    b_arr [N][N];
  logic [W-1:0]    s_arr [N][N];
  logic            sat_q;
  logic [CW-1:0]   i_cnt, j_cnt, k_cnt;
  logic [AW-1:0]   acc;

  logic            accept;
  logic            last_k;
  logic            last_elem;
  logic [2*W-1:0]  prod;
  logic [AW-1:0]   sum;
  logic [W-1:0]    res;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (last_elem) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_k    = (k_cnt == LAST);
  assign last_elem = (state == COMPUTE) && last_k && (j_cnt == LAST) && (i_cnt == LAST);

  // Multiply-accumulate. k=0 starts a fresh dot product instead of adding to
  // the previous element's total, so acc never has to be cleared between elements.
  assign prod = {{W{1'b0}}, a_arr[i_cnt][k_cnt]} * {{W{1'b0}}, b_arr[k_cnt][j_cnt]};
  assign sum  = (k_cnt == '0) ? {{CW{1'b0}}, prod} : acc + {{CW{1'b0}}, prod};
  assign res  = (sat_q && (sum > SAT_MAX)) ? {W{1'b1}} : sum[W-1:0];

  // Operand capture, index counters, accumulator and result storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_arr[r][c] <= '0;
          b_arr[r][c] <= '0;
          s_arr[r][c] <= '0;
        end
      end
      sat_q <= 1'b0;
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
      acc   <= '0;
    end else if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_arr[r][c] <= a_mat[(r*N+c)*W +: W];
          b_arr[r][c] <= b_mat[(r*N+c)*W +: W];
          s_arr[r][c] <= '0;
        end
      end
      sat_q <= sat_en;
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
      acc   <= '0;
    end else if (state == COMPUTE) begin
      acc <= sum;
      if (last_k) begin
        s_arr[i_cnt][j_cnt] <= res;
        k_cnt <= '0;
        if (j_cnt == LAST) begin
          j_cnt <= '0;
          // i wraps explicitly because N need not be a power of two.
          i_cnt <= (i_cnt == LAST) ? '0 : i_cnt + 1'b1;
        end else begin
          j_cnt <= j_cnt + 1'b1;
        end
      end else begin
        k_cnt <= k_cnt + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign s_mat[(r*N+c)*W +: W] = s_arr[r][c];
    end
  end

endmodule

// File: tb/tb_mat_mul_seq.sv
module tb_mat_mul_seq;

  logic clk;
  logic rst_n;

  logic        iv2, ir2, sat2, ov2, or2;
  logic [31:0] a2, b2, s2;

  logic        iv3, ir3, sat3, ov3, or3;
  logic [71:0] a3, b3, s3;

  int total = 0;
  int bad   = 0;

  logic [71:0] q2[$];
  logic [71:0] q3[$];

  mat_mul_seq #(.N(2), .W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2), .a_mat(a2), .b_mat(b2), .sat_en(sat2),
    .out_valid(ov2), .out_ready(or2), .s_mat(s2)
  );

  mat_mul_seq #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv3), .in_ready(ir3), .a_mat(a3), .b_mat(b3), .sat_en(sat3),
    .out_valid(ov3), .out_ready(or3), .s_mat(s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: textbook triple loop on integers, then wrap or clamp.
  function automatic logic [71:0] model(input int n, input logic [71:0] a,
                                        input logic [71:0] b, input logic sat);
    logic [71:0] r;
    int unsigned sm;
    r = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        sm = 0;
        for (int k = 0; k < n; k++)
          sm += a[(i*n+k)*8 +: 8] * b[(k*n+j)*8 +: 8];
        r[(i*n+j)*8 +: 8] = (sat && sm > 255) ? 8'hFF : sm[7:0];
      end
    end
    return r;
  endfunction

  // Scoreboard checkers: a handshake seen between edges pops one expectation.
  always @(negedge clk) begin
    if (rst_n && ov2 && or2) begin
      chk("sb2_pending", q2.size() > 0, 1);
      if (q2.size() > 0) chk("s2_result", s2, q2.pop_front());
    end
    if (rst_n && ov3 && or3) begin
      chk("sb3_pending", q3.size() > 0, 1);
      if (q3.size() > 0) chk("s3_result", s3, q3.pop_front());
    end
  end

  // One N=2 operation; hold>0 applies backpressure with in_valid pulses.
  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int hold, input string tag, output logic [31:0] res);
    int n, lat, viol, bpv;
    a2 = a; b2 = b; sat2 = s; iv2 = 1'b1;
    n = 0;
    while (!ir2 && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_accept_timeout"}, n < 50, 1);
    q2.push_back(model(2, {40'd0, a}, {40'd0, b}, s));
    @(posedge clk); #1;
    iv2 = 1'b0; a2 = ~a; b2 = ~b; sat2 = ~s;
    lat = 0; viol = 0;
    while (!ov2 && lat < 50) begin
      if (ir2) viol++;
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_in_ready_busy"}, viol, 0);
    res = s2;
    bpv = 0;
    for (int h = 0; h < hold; h++) begin
      iv2 = h[0]; a2 = $urandom; b2 = $urandom;
      @(posedge clk); #1;
      if (!ov2 || ir2 || s2 !== res) bpv++;
    end
    iv2 = 1'b0;
    if (hold > 0) chk({tag, "_backpressure"}, bpv, 0);
    or2 = 1'b1;
    @(posedge clk); #1;
    or2 = 1'b0;
    chk({tag, "_ov_drop"}, ov2, 0);
    chk({tag, "_ir_rise"}, ir2, 1);
    chk({tag, "_sb_drained"}, q2.size(), 0);
  endtask

  task automatic run3(input logic [71:0] a, input logic [71:0] b, input logic s,
                      input string tag);
    int n, lat;
    a3 = a; b3 = b; sat3 = s; iv3 = 1'b1;
    n = 0;
    while (!ir3 && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_accept_timeout"}, n < 100, 1);
    q3.push_back(model(3, a, b, s));
    @(posedge clk); #1;
    iv3 = 1'b0; a3 = '0; b3 = '0;
    lat = 0;
    while (!ov3 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, lat, 27);
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;
    chk({tag, "_ov_drop"}, ov3, 0);
    chk({tag, "_sb_drained"}, q3.size(), 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [71:0] id3, seq3;
    int n;

    rst_n = 1'b0;
    iv2 = 0; sat2 = 0; or2 = 0; a2 = '0; b2 = '0;
    iv3 = 0; sat3 = 0; or3 = 0; a3 = '0; b3 = '0;
    #1;
    chk("rst_ir2", ir2, 1);
    chk("rst_ov2", ov2, 0);
    chk("rst_s2",  s2,  0);
    chk("rst_ir3", ir3, 1);
    chk("rst_ov3", ov3, 0);
    chk("rst_s3",  s3,  0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    run2(32'h04030201, 32'h08070605, 1'b0, 0, "basic", r);
    chk("basic_value", r, 32'h322B1613);
    run2(32'h10101010, 32'h10101010, 1'b0, 0, "wrap", r);
    chk("wrap_value", r, 32'h00000000);
    run2(32'h10101010, 32'h10101010, 1'b1, 0, "sat", r);
    chk("sat_value", r, 32'hFFFFFFFF);
    run2($urandom, $urandom, 1'($urandom), 5, "bp", r);
    run2(32'h00000000, 32'hA5A5A5A5, 1'b1, 0, "zero", r);
    chk("zero_value", r, 32'h0);

    // Reset during the third COMPUTE cycle abandons the operation.
    a2 = 32'h04030201; b2 = 32'h01000001; sat2 = 1'b0; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ir2", ir2, 1);
    chk("midrst_ov2", ov2, 0);
    chk("midrst_s2",  s2,  0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run2(32'h01000001, 32'h04030201, 1'b0, 0, "post_rst", r);
    chk("post_rst_value", r, 32'h04030201);

    // Back-to-back with in_valid and out_ready held high.
    chk("b2b_idle", ir2, 1);
    or2 = 1'b1; sat2 = 1'b0; iv2 = 1'b1;
    a2 = 32'h0F0E0D0C; b2 = 32'h03020104;
    q2.push_back(model(2, {40'd0, a2}, {40'd0, b2}, 1'b0));
    @(posedge clk); #1;
    a2 = 32'hFF80407F; b2 = 32'h11223344; sat2 = 1'b1;
    n = 0;
    while (!ir2 && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2b_spacing", n + 1, 10);
    q2.push_back(model(2, {40'd0, a2}, {40'd0, b2}, 1'b1));
    @(posedge clk); #1;
    iv2 = 1'b0;
    n = 0;
    while (!ov2 && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2b_latency2", n, 8);
    @(posedge clk); #1;
    or2 = 1'b0;
    chk("b2b_sb_drained", q2.size(), 0);

    // N=3: identity x B, then all-0xFF with saturation.
    id3 = '0;
    id3[7:0] = 8'd1; id3[39:32] = 8'd1; id3[71:64] = 8'd1;
    for (int e = 0; e < 9; e++) seq3[e*8 +: 8] = 8'(e + 1);
    run3(id3, seq3, 1'b0, "n3_ident");
    chk("n3_ident_value", s3, seq3);
    run3({72{1'b1}}, {72{1'b1}}, 1'b1, "n3_sat");
    chk("n3_sat_value", s3, {72{1'b1}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
